// File: rtl/cnn_stream_pkg.sv
// Shared constants and FSM encoding for the CNN pixel-input streamer.
package cnn_stream_pkg;

    localparam int DATA_W  = 32;
    localparam int NUM_PIX = 784;
    localparam int ADDR_W  = 10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STREAM  = 2'd1,
        WAIT_C1 = 2'd2
    } state_t;

endpackage

// File: rtl/image_buf.sv
// Simple dual-port image buffer: one synchronous write port, one registered read port.
module image_buf #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 784,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_reg;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read register holds between reads so it can drive the consumer directly.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_data_reg <= '0;
        end else if (rd_en) begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/cnn_image_streamer.sv
// Streams a preloaded image into CNN_top: start/din handshake, held until conv1_done.
module cnn_image_streamer
    import cnn_stream_pkg::*;
#(
    parameter int DATA_W  = cnn_stream_pkg::DATA_W,
    parameter int NUM_PIX = cnn_stream_pkg::NUM_PIX,
    parameter int ADDR_W  = cnn_stream_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              go,
    input  logic              din_ready,
    input  logic              conv1_done,
    output logic              start,
    output logic [DATA_W-1:0] din,
    output logic              busy,
    output logic              img_done,
    output logic              err_early,
    output logic              err_overrun
);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] rd_ptr_reg;
    logic              img_done_reg;
    logic              err_early_reg;
    logic              err_overrun_reg;

    logic wr_accept;
    logic accept_go;
    logic send_pix;
    logic last_pix;

    assign wr_accept = wr_en && !busy && (wr_addr < ADDR_W'(NUM_PIX));
    assign accept_go = (state_reg == IDLE) && go;
    // An early conv1_done cancels a pixel requested on the same edge.
    assign send_pix  = (state_reg == STREAM) && din_ready && !conv1_done;
    assign last_pix  = (rd_ptr_reg == ADDR_W'(NUM_PIX - 1));

    image_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (NUM_PIX),
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en   (wr_accept),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (send_pix),
        .rd_addr (rd_ptr_reg),
        .rd_data (din)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (go) state_next = STREAM;
            STREAM: begin
                if (conv1_done)              state_next = IDLE;
                else if (send_pix && last_pix) state_next = WAIT_C1;
            end
            WAIT_C1: if (conv1_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        start       = (state_reg != IDLE);
        busy        = (state_reg != IDLE);
        img_done    = img_done_reg;
        err_early   = err_early_reg;
        err_overrun = err_overrun_reg;
    end

    // Pointer ends at NUM_PIX after the final pixel and stays there in WAIT_C1.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr_reg      <= '0;
            img_done_reg    <= 1'b0;
            err_early_reg   <= 1'b0;
            err_overrun_reg <= 1'b0;
        end else begin
            img_done_reg <= (state_reg == WAIT_C1) && conv1_done;
            if (accept_go) begin
                rd_ptr_reg      <= '0;
                err_early_reg   <= 1'b0;
                err_overrun_reg <= 1'b0;
            end else begin
                if (send_pix) begin
                    rd_ptr_reg <= rd_ptr_reg + ADDR_W'(1);
                end
                if ((state_reg == STREAM) && conv1_done) begin
                    err_early_reg <= 1'b1;
                end
                if ((state_reg == WAIT_C1) && din_ready) begin
                    err_overrun_reg <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cnn_image_streamer.sv
// Scoreboard bench: stimulus queues expected pixels, a monitor checks din after each taken edge.
module tb_cnn_image_streamer;
    import cnn_stream_pkg::*;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              go = 1'b0;
    logic              din_ready = 1'b0;
    logic              conv1_done = 1'b0;
    logic              start;
    logic [DATA_W-1:0] din;
    logic              busy;
    logic              img_done;
    logic              err_early;
    logic              err_overrun;

    int vectors = 0;
    int miscompares = 0;
    logic [DATA_W-1:0] exp_q[$];

    cnn_image_streamer dut (
        .clk         (clk),
        .rstn        (rstn),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .go          (go),
        .din_ready   (din_ready),
        .conv1_done  (conv1_done),
        .start       (start),
        .din         (din),
        .busy        (busy),
        .img_done    (img_done),
        .err_early   (err_early),
        .err_overrun (err_overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] pix(input int i);
        return DATA_W'(i - 392);
    endfunction

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%h), required %0d (0x%h)", name, $signed(act), act, $signed(exp), exp);
        end
    endtask

    // Monitor: a din_ready edge with a queued pixel means din must show it just after the edge.
    always @(posedge clk) begin
        if (din_ready && exp_q.size() > 0) begin
            logic [DATA_W-1:0] e;
            e = exp_q.pop_front();
            #1;
            chk("din_pixel", din, e);
        end
    end

    task automatic load_image();
        for (int i = 0; i < NUM_PIX; i++) begin
            wr_en = 1'b1; wr_addr = ADDR_W'(i); wr_data = pix(i);
            @(negedge clk);
        end
        wr_en = 1'b0;
    endtask

    task automatic pulse_go();
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        chk("start_after_go", {31'd0, start}, 32'd1);
        chk("busy_after_go", {31'd0, busy}, 32'd1);
    endtask

    task automatic stream(input int first, input int n, input int gap);
        for (int k = first; k < first + n; k++) begin
            din_ready = 1'b0;
            repeat (gap) @(negedge clk);
            din_ready = 1'b1;
            exp_q.push_back(pix(k));
            @(negedge clk);
        end
        din_ready = 1'b0;
    endtask

    task automatic finish_ok(input string tag);
        conv1_done = 1'b1;
        @(negedge clk);
        conv1_done = 1'b0;
        chk({tag, "_start_low"}, {31'd0, start}, 32'd0);
        chk({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
        chk({tag, "_img_done"}, {31'd0, img_done}, 32'd1);
        @(negedge clk);
        chk({tag, "_img_done_pulse"}, {31'd0, img_done}, 32'd0);
    endtask

    initial begin
        @(negedge clk);
        chk("rst_start", {31'd0, start}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_din", din, 32'd0);
        chk("rst_flags", {29'd0, img_done, err_early, err_overrun}, 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        load_image();

        // 1: continuous stream, conv1_done ten cycles later
        pulse_go();
        chk("t1_din_before", din, 32'd0);
        stream(0, NUM_PIX, 0);
        chk("t1_last_din", din, pix(783));
        chk("t1_start_held", {31'd0, start}, 32'd1);
        repeat (10) @(negedge clk);
        chk("t1_din_hold", din, pix(783));
        finish_ok("t1");
        $display("t1 continuous stream done, vectors=%0d", vectors);

        // 2: din_ready 1,0,0,1,...
        pulse_go();
        stream(0, NUM_PIX, 2);
        finish_ok("t2");
        chk("t2_no_overrun", {31'd0, err_overrun}, 32'd0);
        $display("t2 gapped stream done, vectors=%0d", vectors);

        // 3: early conv1_done after 100 pixels, with a same-edge din_ready
        pulse_go();
        stream(0, 100, 0);
        din_ready = 1'b1; conv1_done = 1'b1;
        @(negedge clk);
        din_ready = 1'b0; conv1_done = 1'b0;
        chk("t3_start_low", {31'd0, start}, 32'd0);
        chk("t3_err_early", {31'd0, err_early}, 32'd1);
        chk("t3_no_img_done", {31'd0, img_done}, 32'd0);
        chk("t3_din_frozen", din, 32'hFFFF_FEDB);
        din_ready = 1'b1;
        @(negedge clk);
        din_ready = 1'b0;
        chk("t3_din_idle_hold", din, pix(99));
        $display("t3 early abort done, vectors=%0d", vectors);

        // 4: overrun after the final pixel
        pulse_go();
        chk("t4_err_early_clr", {31'd0, err_early}, 32'd0);
        stream(0, NUM_PIX, 0);
        chk("t4_no_overrun_yet", {31'd0, err_overrun}, 32'd0);
        din_ready = 1'b1;
        repeat (3) @(negedge clk);
        din_ready = 1'b0;
        chk("t4_err_overrun", {31'd0, err_overrun}, 32'd1);
        chk("t4_din_391", din, 32'd391);
        finish_ok("t4");
        chk("t4_overrun_sticky", {31'd0, err_overrun}, 32'd1);
        $display("t4 overrun done, vectors=%0d", vectors);

        // 5: go and a buffer write during a stream are both ignored
        pulse_go();
        chk("t5_overrun_clr", {31'd0, err_overrun}, 32'd0);
        stream(0, 3, 0);
        go = 1'b1; wr_en = 1'b1; wr_addr = ADDR_W'(5); wr_data = 32'h7FFF_FFFF;
        @(negedge clk);
        go = 1'b0; wr_en = 1'b0;
        stream(3, NUM_PIX - 3, 0);
        finish_ok("t5");
        pulse_go();
        stream(0, 6, 0);
        chk("t5_pix5_next", din, 32'hFFFF_FE7D);
        conv1_done = 1'b1;
        @(negedge clk);
        conv1_done = 1'b0;
        $display("t5 busy write/go drop done, vectors=%0d", vectors);

        // 6: asynchronous reset at pixel 400, then restart with go+conv1_done together
        pulse_go();
        stream(0, 400, 0);
        #2 rstn = 1'b0;
        #1;
        chk("t6_rst_start", {31'd0, start}, 32'd0);
        chk("t6_rst_busy", {31'd0, busy}, 32'd0);
        chk("t6_rst_din", din, 32'd0);
        chk("t6_rst_flags", {29'd0, img_done, err_early, err_overrun}, 32'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        conv1_done = 1'b1;
        pulse_go();
        conv1_done = 1'b0;
        chk("t6_go_wins_err", {31'd0, err_early}, 32'd0);
        stream(0, 2, 0);
        chk("t6_restart_pix1", din, pix(1));
        $display("t6 reset restart done, vectors=%0d", vectors);

        @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
